// File: rtl/ssd_display_driver_pkg.sv
// Shared definitions for the seven-segment display driver: converter FSM states,
// the active-low segment decode table and idle output constants.
package ssd_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry n is the glyph for digit n.
  localparam logic [0:9][6:0] SEG_TABLE = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] result;
    result = SEG_BLANK;
    if (digit <= 4'd9) result = SEG_TABLE[digit];
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, IN_W shift
// cycles per conversion, result held stable on bcd from DONE until the next start.
module bin2bcd_seq
  import ssd_display_driver_pkg::*;
#(
  parameter int IN_W = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic [15:0]     bcd,
  output logic            done,
  output logic            busy
);

  localparam int ITER_W = $clog2(IN_W);

  bcd_state_e        state_q, state_d;
  logic [IN_W-1:0]   bin_q;
  logic [15:0]       bcd_q;
  logic [15:0]       bcd_adj;
  logic [ITER_W-1:0] iter_q;
  logic              busy_q;
  logic              last_iter;

  assign last_iter = (iter_q == ITER_W'(IN_W - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        ST_SHIFT: begin
          // Adjust then shift {bcd,bin} left by one; the bin MSB enters the BCD LSB.
          bcd_q  <= {bcd_adj[14:0], bin_q[IN_W-1]};
          bin_q  <= {bin_q[IN_W-2:0], 1'b0};
          iter_q <= iter_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign done = (state_q == ST_DONE);
  assign busy = busy_q;

endmodule

// File: rtl/ssd_display_driver.sv
// Four-digit multiplexed seven-segment driver for a 13-bit debug value.
// Define SSD_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module ssd_display_driver
  import ssd_display_driver_pkg::*;
#(
  parameter int IN_W         = 13,
  parameter int REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] num,
  output logic [3:0]      anode,
  output logic [6:0]      seg,
  output logic            busy
);

  logic [IN_W-1:0]         last_num_q;
  logic [3:0][3:0]         digit_q;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [3:0]              anode_q;
  logic [6:0]              seg_q;

  logic        start;
  logic        conv_idle;
  logic        conv_done;
  logic        conv_busy;
  logic [15:0] conv_bcd;
  logic [1:0]  sel;
  logic [3:0]  blank_mask;
  logic [6:0]  seg_d;

  assign start     = (num != last_num_q);
  assign conv_idle = !conv_busy && !conv_done;

  bin2bcd_seq #(
    .IN_W (IN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (num),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  assign sel = cnt_q[REFRESH_BITS-1 -: 2];

`ifdef SSD_LZ_BLANK_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = (digit_q[3] == 4'd0);
    blank_mask[2] = blank_mask[3] && (digit_q[2] == 4'd0);
    blank_mask[1] = blank_mask[2] && (digit_q[1] == 4'd0);
  end
`else
  assign blank_mask = 4'b0000;
`endif

  assign seg_d = blank_mask[sel] ? SEG_BLANK : seg_decode(digit_q[sel]);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_num_q <= '0;
      digit_q    <= '0;
      cnt_q      <= '0;
      anode_q    <= ANODE_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      anode_q <= ~(4'b0001 << sel);
      seg_q   <= seg_d;
      // The converter only accepts a start while idle, so last_num follows the same rule.
      if (start && conv_idle) last_num_q <= num;
      // Whole result is copied in one edge, so a partial conversion is never displayed.
      if (conv_done) digit_q <= conv_bcd;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign busy  = conv_busy;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Scoreboard bench for ssd_display_driver: the full expected cycle-by-cycle display
// schedule is queued up front and a negedge monitor compares against it.
module tb_ssd_display_driver;

  localparam int IN_W   = 13;
  localparam int REF_B  = 4;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] sg;
    logic       bz;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] num = '0;
  logic [3:0]      anode;
  logic [6:0]      seg;
  logic            busy;

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t sb_q[$];

  ssd_display_driver #(
    .IN_W         (IN_W),
    .REFRESH_BITS (REF_B)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .num   (num),
    .anode (anode),
    .seg   (seg),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Cycles [from,to] show digits d3..d0; refresh counter was zero at edge 'base'.
  task automatic push_disp(input int from, input int to, input int base,
                           input int d3, input int d2, input int d1, input int d0,
                           input int bz_lo, input int bz_hi);
    int         dg[4];
    int         sel;
    bit         blank;
    logic [3:0] one;
    exp_t       e;
    dg  = '{d0, d1, d2, d3};
    one = 4'b0001;
    for (int k = from; k <= to; k++) begin
      sel   = ((k - base) >> 2) & 3;
      blank = 1'b0;
`ifdef SSD_LZ_BLANK_EN
      if (sel > 0) begin
        blank = 1'b1;
        for (int j = sel; j < 4; j++) if (dg[j] != 0) blank = 1'b0;
      end
`endif
      e.cyc = k;
      e.an  = ~(one << sel);
      e.sg  = blank ? 7'b1111111 : ref_seg(dg[sel]);
      e.bz  = (k >= bz_lo) && (k <= bz_hi);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_off(input int from, input int to);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.cyc = k;
      e.an  = 4'b1111;
      e.sg  = 7'b1111111;
      e.bz  = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_edge(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL stale@%0d: checked at cycle %0d, due %0d", e.cyc, cyc, e.cyc);
      end else if (anode !== e.an || seg !== e.sg || busy !== e.bz) begin
        n_bad++;
        $display("FAIL disp@%0d: got anode=%b seg=%b busy=%b, want anode=%b seg=%b busy=%b",
                 cyc, anode, seg, busy, e.an, e.sg, e.bz);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit hit at cycle %0d, want finish by cycle 224", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then 0000 until 1234 (set after edge 8) lands 16 edges later.
    push_off(1, 3);
    push_disp(4,   23,  4,   0, 0, 0, 0,  9,   21);
    push_disp(24,  55,  4,   1, 2, 3, 4,  41,  53);
    push_disp(56,  87,  4,   8, 1, 9, 1,  73,  85);
    push_disp(88,  119, 4,   0, 0, 0, 0,  105, 117);
    // 57 arrives mid-conversion of 100; it restarts only after DONE.
    push_disp(120, 134, 4,   0, 1, 0, 0,  120, 132);
    push_disp(135, 158, 4,   0, 0, 5, 7,  152, 158);
    // Reset pulse at edge 159 aborts 4321; it restarts from last_num=0.
    push_off(159, 159);
    push_disp(160, 174, 160, 0, 0, 0, 0,  160, 172);
    push_disp(175, 223, 160, 4, 3, 2, 1,  1,   0);

    wait_edge(3);   rst = 1'b0;
    wait_edge(8);   num = 13'd1234;
    wait_edge(40);  num = 13'd8191;
    wait_edge(72);  num = 13'd0;
    wait_edge(104); num = 13'd100;
    wait_edge(109); num = 13'd57;
    wait_edge(151); num = 13'd4321;
    wait_edge(158); rst = 1'b1;
    wait_edge(159); rst = 1'b0;
    wait_edge(224);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expectations unchecked, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
